alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing a single ALU, round-robin between simultaneous requesters.
// Latency: accept edge, one EXEC edge, then response held in RESP until consumed.
// Backpressure: one operation in flight; req_ready stays low until the response is consumed.

`ifndef CPU_WSIZE
`define CPU_WSIZE 32
`endif
`ifndef ALU_OSIZE
`define ALU_OSIZE 2
`endif

// Combinational ALU with opcodes AND, OR, ADD, SUB, SLT, LUI and NOR.
// Latency: zero (purely combinational).
// Backpressure: none; outputs follow the inputs.
module alu #(
  parameter int WSIZE = `CPU_WSIZE,
  parameter int OSIZE = `ALU_OSIZE + 1
) (
  output logic [WSIZE-1:0] r,
  output logic             zero,
  output logic             ovf,
  input  logic [OSIZE-1:0] op,
  input  logic [WSIZE-1:0] a,
  input  logic [WSIZE-1:0] b
);

  localparam logic [OSIZE-1:0] OP_AND = OSIZE'(0);
  localparam logic [OSIZE-1:0] OP_OR  = OSIZE'(1);
  localparam logic [OSIZE-1:0] OP_ADD = OSIZE'(2);
  localparam logic [OSIZE-1:0] OP_SUB = OSIZE'(3);
  localparam logic [OSIZE-1:0] OP_SLT = OSIZE'(4);
  localparam logic [OSIZE-1:0] OP_LUI = OSIZE'(5);
  localparam logic [OSIZE-1:0] OP_NOR = OSIZE'(6);

  // Result, signed overflow (ADD/SUB only) and zero flag; unknown opcodes yield 0.
  always_comb begin
    r   = '0;
    ovf = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin
        r   = a + b;
        ovf = (a[WSIZE-1] == b[WSIZE-1]) && (r[WSIZE-1] != a[WSIZE-1]);
      end
      OP_SUB: begin
        r   = a - b;
        ovf = (a[WSIZE-1] != b[WSIZE-1]) && (r[WSIZE-1] != a[WSIZE-1]);
      end
      OP_SLT: r = {{(WSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LUI: r = b << (WSIZE / 2);
      OP_NOR: r = ~(a | b);
      default: r = '0;
    endcase
    zero = (r == '0);
  end

endmodule

module alu_arbiter #(
  parameter int WSIZE = `CPU_WSIZE,
  parameter int OSIZE = `ALU_OSIZE + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [OSIZE-1:0] req_op_0,
  input  logic [WSIZE-1:0] req_a_0,
  input  logic [WSIZE-1:0] req_b_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [OSIZE-1:0] req_op_1,
  input  logic [WSIZE-1:0] req_a_1,
  input  logic [WSIZE-1:0] req_b_1,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WSIZE-1:0] rsp_r_0,
  output logic             rsp_zero_0,
  output logic             rsp_ovf_0,
  output logic             rsp_err_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WSIZE-1:0] rsp_r_1,
  output logic             rsp_zero_1,
  output logic             rsp_ovf_1,
  output logic             rsp_err_1,
  output logic [15:0]      gnt_cnt_0,
  output logic [15:0]      gnt_cnt_1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [OSIZE-1:0] OP_NOR = OSIZE'(6);

  logic [1:0]       state;
  logic             prio;
  logic             grant;
  logic [OSIZE-1:0] op_q;
  logic [WSIZE-1:0] a_q;
  logic [WSIZE-1:0] b_q;

  logic             rsp_valid_q;
  logic [WSIZE-1:0] rsp_r_q;
  logic             rsp_zero_q;
  logic             rsp_ovf_q;
  logic             rsp_err_q;
  logic [15:0]      cnt_0;
  logic [15:0]      cnt_1;

  logic [WSIZE-1:0] alu_r;
  logic             alu_zero;
  logic             alu_ovf;
  logic             op_mapped;
  logic             rsp_ready_gnt;
  logic             sel_0;
  logic             sel_1;

  // The single shared ALU only ever sees the latched operands, so requester
  // inputs may change freely once the operation has been accepted.
  alu #(
    .WSIZE(WSIZE),
    .OSIZE(OSIZE)
  ) u_alu (
    .r    (alu_r),
    .zero (alu_zero),
    .ovf  (alu_ovf),
    .op   (op_q),
    .a    (a_q),
    .b    (b_q)
  );

  // Opcodes 0..6 are implemented; everything above NOR is reported as an error.
  assign op_mapped = (op_q <= OP_NOR);

  // Grant decision in IDLE: prio breaks ties, a lone requester always wins.
  always_comb begin
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    if (state == IDLE && !rst) begin
      req_ready_0 = req_valid_0 & (!prio | !req_valid_1);
      req_ready_1 = req_valid_1 & ( prio | !req_valid_0);
    end
  end

  assign rsp_ready_gnt = grant ? rsp_ready_1 : rsp_ready_0;

  // Arbitration FSM with operand, response and grant-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      grant       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_r_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_0       <= 16'd0;
      cnt_1       <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready_0) begin
            op_q  <= req_op_0;
            a_q   <= req_a_0;
            b_q   <= req_b_0;
            grant <= 1'b0;
            cnt_0 <= cnt_0 + 16'd1;
            state <= EXEC;
          end else if (req_ready_1) begin
            op_q  <= req_op_1;
            a_q   <= req_a_1;
            b_q   <= req_b_1;
            grant <= 1'b1;
            cnt_1 <= cnt_1 + 16'd1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          if (op_mapped) begin
            rsp_r_q    <= alu_r;
            rsp_zero_q <= alu_zero;
            rsp_ovf_q  <= alu_ovf;
            rsp_err_q  <= 1'b0;
          end else begin
            rsp_r_q    <= '0;
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_err_q  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          // Response registers hold until the granted requester takes them.
          if (rsp_ready_gnt) begin
            rsp_valid_q <= 1'b0;
            prio        <= ~grant;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response fields only appear on the granted port while a response is pending.
  assign sel_0 = rsp_valid_q & ~grant;
  assign sel_1 = rsp_valid_q &  grant;

  assign rsp_valid_0 = sel_0;
  assign rsp_r_0     = sel_0 ? rsp_r_q : '0;
  assign rsp_zero_0  = sel_0 & rsp_zero_q;
  assign rsp_ovf_0   = sel_0 & rsp_ovf_q;
  assign rsp_err_0   = sel_0 & rsp_err_q;

  assign rsp_valid_1 = sel_1;
  assign rsp_r_1     = sel_1 ? rsp_r_q : '0;
  assign rsp_zero_1  = sel_1 & rsp_zero_q;
  assign rsp_ovf_1   = sel_1 & rsp_ovf_q;
  assign rsp_err_1   = sel_1 & rsp_err_q;

  assign gnt_cnt_0 = cnt_0;
  assign gnt_cnt_1 = cnt_1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with WSIZE=8 and hand-computed results.
// Latency: accept edge, EXEC edge, then RESP until the response is consumed.
// Backpressure: exercises held responses and simultaneous requesters.
module tb_alu_arbiter;

  localparam int W = 8;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_LUI = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_BAD = 3'd7;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_0, req_valid_1;
  logic         req_ready_0, req_ready_1;
  logic [2:0]   req_op_0, req_op_1;
  logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic         rsp_valid_0, rsp_valid_1;
  logic         rsp_ready_0, rsp_ready_1;
  logic [W-1:0] rsp_r_0, rsp_r_1;
  logic         rsp_zero_0, rsp_ovf_0, rsp_err_0;
  logic         rsp_zero_1, rsp_ovf_1, rsp_err_1;
  logic [15:0]  gnt_cnt_0, gnt_cnt_1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         who;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    bit         z;
    bit         o;
    bit         e;
  } vec_t;

  vec_t vecs [8];

  alu_arbiter #(.WSIZE(W), .OSIZE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_0 (req_valid_0),
    .req_ready_0 (req_ready_0),
    .req_op_0    (req_op_0),
    .req_a_0     (req_a_0),
    .req_b_0     (req_b_0),
    .req_valid_1 (req_valid_1),
    .req_ready_1 (req_ready_1),
    .req_op_1    (req_op_1),
    .req_a_1     (req_a_1),
    .req_b_1     (req_b_1),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_ready_0 (rsp_ready_0),
    .rsp_r_0     (rsp_r_0),
    .rsp_zero_0  (rsp_zero_0),
    .rsp_ovf_0   (rsp_ovf_0),
    .rsp_err_0   (rsp_err_0),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_ready_1 (rsp_ready_1),
    .rsp_r_1     (rsp_r_1),
    .rsp_zero_1  (rsp_zero_1),
    .rsp_ovf_1   (rsp_ovf_1),
    .rsp_err_1   (rsp_err_1),
    .gnt_cnt_0   (gnt_cnt_0),
    .gnt_cnt_1   (gnt_cnt_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One lone request from requester 'who', checked end to end.
  task automatic do_op(input string tag, input bit who, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] er,
                       input bit ez, input bit eo, input bit ee);
    if (!who) begin
      req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b; rsp_ready_0 = 1'b1;
    end else begin
      req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b; rsp_ready_1 = 1'b1;
    end
    #1;
    chk({tag, "_rdy"}, 32'(who ? req_ready_1 : req_ready_0), 32'd1);
    tick();
    // Scramble operands after acceptance; the result must not move.
    if (!who) begin
      req_valid_0 = 1'b0; req_op_0 = ~op; req_a_0 = ~a; req_b_0 = ~b;
    end else begin
      req_valid_1 = 1'b0; req_op_1 = ~op; req_a_1 = ~a; req_b_1 = ~b;
    end
    #1;
    chk({tag, "_exec_vld"}, 32'(who ? rsp_valid_1 : rsp_valid_0), 32'd0);
    tick();
    chk({tag, "_vld"},  32'(who ? rsp_valid_1 : rsp_valid_0), 32'd1);
    chk({tag, "_r"},    32'(who ? rsp_r_1 : rsp_r_0), 32'(er));
    chk({tag, "_zero"}, 32'(who ? rsp_zero_1 : rsp_zero_0), 32'(ez));
    chk({tag, "_ovf"},  32'(who ? rsp_ovf_1 : rsp_ovf_0), 32'(eo));
    chk({tag, "_err"},  32'(who ? rsp_err_1 : rsp_err_0), 32'(ee));
    chk({tag, "_oth_vld"}, 32'(who ? rsp_valid_0 : rsp_valid_1), 32'd0);
    chk({tag, "_oth_r"},   32'(who ? rsp_r_0 : rsp_r_1), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(who ? rsp_valid_1 : rsp_valid_0), 32'd0);
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, OP_SLT, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, OP_LUI, 8'h00, 8'h0A, 8'hA0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, OP_NOR, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, OP_BAD, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, OP_OR,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_op_0 = '0; req_op_1 = '0;
    req_a_0 = '0; req_b_0 = '0; req_a_1 = '0; req_b_1 = '0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    tick();
    tick();

    // Reset state; ready must stay low while rst is high.
    req_valid_0 = 1'b1;
    #1;
    chk("rst_rdy0", 32'(req_ready_0), 32'd0);
    chk("rst_vld0", 32'(rsp_valid_0), 32'd0);
    chk("rst_vld1", 32'(rsp_valid_1), 32'd0);
    chk("rst_r0",   32'(rsp_r_0), 32'd0);
    chk("rst_cnt0", 32'(gnt_cnt_0), 32'd0);
    chk("rst_cnt1", 32'(gnt_cnt_1), 32'd0);
    req_valid_0 = 1'b0;
    rst = 1'b0;
    tick();

    // Signed overflow on ADD.
    do_op("add_ovf", 1'b0, OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    chk("add_cnt0", 32'(gnt_cnt_0), 32'd1);

    // Table of assorted opcodes, including an unmapped one.
    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].r, vecs[i].z, vecs[i].o, vecs[i].e);
    chk("vec_cnt0", 32'(gnt_cnt_0), 32'd5);
    chk("vec_cnt1", 32'(gnt_cnt_1), 32'd4);

    // Simultaneous requests right after reset: req0 first, then req1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid_0 = 1'b1; req_op_0 = OP_SUB; req_a_0 = 8'h05; req_b_0 = 8'h05;
    req_valid_1 = 1'b1; req_op_1 = OP_OR;  req_a_1 = 8'h0F; req_b_1 = 8'hF0;
    #1;
    chk("both_rdy0", 32'(req_ready_0), 32'd1);
    chk("both_rdy1", 32'(req_ready_1), 32'd0);
    tick();
    req_valid_0 = 1'b0;
    tick();
    chk("both_vld0", 32'(rsp_valid_0), 32'd1);
    chk("both_r0",   32'(rsp_r_0), 32'h00);
    chk("both_z0",   32'(rsp_zero_0), 32'd1);
    rsp_ready_0 = 1'b1;
    tick();
    rsp_ready_0 = 1'b0;
    #1;
    chk("both_rdy1b", 32'(req_ready_1), 32'd1);
    tick();
    req_valid_1 = 1'b0;
    tick();
    chk("both_vld1", 32'(rsp_valid_1), 32'd1);
    chk("both_r1",   32'(rsp_r_1), 32'hFF);
    chk("both_z1",   32'(rsp_zero_1), 32'd0);
    rsp_ready_1 = 1'b1;
    tick();
    rsp_ready_1 = 1'b0;
    chk("both_cnt0", 32'(gnt_cnt_0), 32'd1);
    chk("both_cnt1", 32'(gnt_cnt_1), 32'd1);

    // Both continuously valid: grants alternate 0,1,0,1.
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_rdy0", k), 32'(req_ready_0), 32'(k % 2 == 0));
      chk($sformatf("rr%0d_rdy1", k), 32'(req_ready_1), 32'(k % 2 == 1));
      tick();
      tick();
      tick();
    end
    chk("rr_cnt0", 32'(gnt_cnt_0), 32'd3);
    chk("rr_cnt1", 32'(gnt_cnt_1), 32'd3);

    // Lone requester 1 is granted back to back even when prio favours 0.
    req_valid_0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("lone%0d_rdy1", k), 32'(req_ready_1), 32'd1);
      tick();
      tick();
      tick();
    end
    chk("lone_cnt1", 32'(gnt_cnt_1), 32'd5);
    req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;

    // Held response on requester 1 while requester 0 waits.
    req_valid_1 = 1'b1; req_op_1 = OP_SLT; req_a_1 = 8'h02; req_b_1 = 8'h03;
    #1;
    chk("hold_rdy1", 32'(req_ready_1), 32'd1);
    tick();
    req_valid_1 = 1'b0;
    req_valid_0 = 1'b1; req_op_0 = OP_ADD; req_a_0 = 8'h01; req_b_0 = 8'h01;
    #1;
    chk("hold_exec_rdy0", 32'(req_ready_0), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_vld1", k), 32'(rsp_valid_1), 32'd1);
      chk($sformatf("hold%0d_r1", k),   32'(rsp_r_1), 32'h01);
      chk($sformatf("hold%0d_rdy0", k), 32'(req_ready_0), 32'd0);
      tick();
    end
    rsp_ready_1 = 1'b1;
    tick();
    rsp_ready_1 = 1'b0;
    chk("hold_done_vld1", 32'(rsp_valid_1), 32'd0);
    chk("hold_idle_rdy0", 32'(req_ready_0), 32'd1);
    req_valid_0 = 1'b0;
    tick();

    // Reset during EXEC discards req1's NOR.
    req_valid_1 = 1'b1; req_op_1 = OP_NOR; req_a_1 = 8'h00; req_b_1 = 8'h00;
    tick();
    req_valid_1 = 1'b0;
    rst = 1'b1;
    req_valid_0 = 1'b1;
    #1;
    chk("rexec_rdy0", 32'(req_ready_0), 32'd0);
    tick();
    rst = 1'b0;
    req_valid_0 = 1'b0;
    chk("rexec_vld1", 32'(rsp_valid_1), 32'd0);
    chk("rexec_r1",   32'(rsp_r_1), 32'd0);
    chk("rexec_cnt0", 32'(gnt_cnt_0), 32'd0);
    chk("rexec_cnt1", 32'(gnt_cnt_1), 32'd0);
    tick();
    tick();
    chk("rexec_late_vld1", 32'(rsp_valid_1), 32'd0);
    req_valid_0 = 1'b1; req_op_0 = OP_AND; req_a_0 = 8'hF0; req_b_0 = 8'h3C;
    req_valid_1 = 1'b1; req_op_1 = OP_OR;  req_a_1 = 8'h01; req_b_1 = 8'h02;
    #1;
    chk("rexec_prio_rdy0", 32'(req_ready_0), 32'd1);
    chk("rexec_prio_rdy1", 32'(req_ready_1), 32'd0);
    tick();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    tick();
    chk("rexec_next_vld0", 32'(rsp_valid_0), 32'd1);
    chk("rexec_next_r0",   32'(rsp_r_0), 32'h30);
    rsp_ready_0 = 1'b1;
    tick();
    rsp_ready_0 = 1'b0;
    chk("rexec_next_done", 32'(rsp_valid_0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
